byte_mem_arbiter: RTL and testbench
===================================

# byte_mem_arbiter

Round-robin arbiter and sequencer for a shared 4-byte register bank (mem0..mem3) read through the team's 4:1 byte multiplexer. Four requesters issue single-byte read or write transactions. The block grants one requester at a time, drives the mux select from the granted address, and performs the write or captures the read data. It returns a one-cycle acknowledge to the winner. The block sits between the requester clients and the byte storage and is the only writer of that storage.

## Interface
- RESET_VAL, 8'h00, value loaded into mem0..mem3 on reset
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous active-low reset
- req  in  4  req[i] = requester i has a transaction pending
- we  in  4  we[i] = 1 write, 0 read, for requester i
- addr  in  8  addr[2i+1:2i] = byte index (0..3) for requester i
- wdata  in  32  wdata[8i+7:8i] = write byte for requester i
- ack  out  4  one-hot, one-cycle pulse to the serviced requester
- rdata  out  8  registered read data; valid while ack != 0
- gnt_id  out  2  index of the requester currently granted
- busy  out  1  high in ACCESS and DONE
- mem0, mem1, mem2, mem3  out  8 each  current storage contents, for observation

## Operation
- Storage: four 8-bit registers. Reads go through a byte_mux instance: sel = granted address, inputs mem0..mem3.
- FSM states and transitions:
  - IDLE: stays in IDLE if req == 0. Otherwise it picks a winner g, latches g, we[g], addr[g] and wdata[g], and moves to ACCESS.
  - ACCESS: lasts 1 cycle, then moves to DONE.
    - Write: at the closing edge, mem[addr] <= wdata and rdata <= wdata.
    - Read: at the closing edge, rdata <= mux output.
    - ack[g] <= 1 at the same edge.
  - DONE: ack[g] is high for this cycle. At the closing edge, ack <= 0, ptr <= (g+1) mod 4, and the FSM returns to IDLE.
- Arbitration: round-robin from pointer ptr, which resets to 0.
  - Requesters are checked in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first one with req set wins.
  - With a single requester active, that requester is always selected.
- Requester protocol:
  - A requester holds req, we, addr and wdata stable from assertion until it sees ack.
  - It drops req at the edge ending the ack cycle, or re-asserts it for a new transaction.
  - req and inputs from non-granted requesters are ignored outside IDLE. Changes to a granted requester's inputs after the grant edge have no effect, because the transaction is latched.
- rdata holds its last value until the next transaction's ACCESS edge.
- gnt_id holds the last grant when idle; its reset value is 0.
- Reset values: state IDLE, ptr 0, ack 4'b0000, rdata 8'h00, gnt_id 0, busy 0, mem0..mem3 = RESET_VAL.
- Reset mid-operation: asserting rst_n low in any state immediately forces all of the above reset values. A write still in ACCESS when rst_n falls is not performed.
- Simultaneous events: a new req arriving in DONE is not sampled until IDLE. A requester that re-asserts req right after its ack competes normally; it loses to any other pending requester because ptr has advanced past it.

## Timing
- Fixed transaction latency of 3 cycles: req sampled at edge E0 (IDLE→ACCESS), data committed at E1, ack/rdata visible in cycle after E1, FSM back in IDLE after E2.
- Maximum throughput is one transaction per 3 cycles.
- Worst-case wait with all four requesters continuously active is 3 transactions, i.e. 9 cycles, before a requester's own grant edge.
- Write data is visible on memN and to subsequent reads from the cycle after E1.
- ack is exactly one cycle wide and never has more than one bit set.
- busy is combinational from state.

## Test plan
- Reset: drive rst_n low with random inputs. Required: ack=0, rdata=00, busy=0, gnt_id=0, mem0..3=00. After release, an idle bus with req=0 keeps busy=0 indefinitely.
- Single write then read: requester 2 writes 8'hA5 to addr 3, then reads addr 3. Required: ack=4'b0100 two cycles after the req edge, mem3=A5, read returns rdata=A5.
- Round-robin fairness: all four requesters hold req=1, each reading a distinct address preloaded with 11/22/33/44. Required: ack order 0,1,2,3,0 with gnt_id matching, each ack spaced 3 cycles apart, and rdata equal to the preloaded byte.
- Pointer wrap: after requester 3 is serviced, requesters 0 and 3 request together. Required: requester 0 wins first, then requester 3.
- Input isolation: during ACCESS, the granted requester changes wdata from 5A to FF. Required: mem stores 5A.
- Reset mid-operation: pull rst_n low during ACCESS of a write of 77 to addr 1. Required: mem1 stays 00, no ack pulse, FSM in IDLE, ptr=0.

Source files
------------

// File: rtl/byte_mem_arbiter.sv
// rtl/byte_mem_arbiter.sv - round-robin arbiter and sequencer for a shared 4-byte register bank
// Grants one of four single-byte requesters at a time; one transaction every three cycles.

module byte_mux (
  input  logic [1:0] sel,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  input  logic [7:0] d3,
  output logic [7:0] y
);
  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end
endmodule

module byte_mem_arbiter #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [3:0]  we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [3:0]  ack,
  output logic [7:0]  rdata,
  output logic [1:0]  gnt_id,
  output logic        busy,
  output logic [7:0]  mem0,
  output logic [7:0]  mem1,
  output logic [7:0]  mem2,
  output logic [7:0]  mem3
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [1:0]  r_gnt;
  logic        r_we;
  logic [1:0]  r_addr;
  logic [7:0]  r_wdata;
  logic [3:0]  r_ack;
  logic [7:0]  r_rdata;
  logic [7:0]  r_mem0;
  logic [7:0]  r_mem1;
  logic [7:0]  r_mem2;
  logic [7:0]  r_mem3;

  logic        w_win_valid;
  logic [1:0]  w_win;
  logic [1:0]  w_idx;
  logic [7:0]  w_mux_y;

  // Scan from ptr upward; the first pending requester wins.
  always_comb begin
    w_win_valid = 1'b0;
    w_win       = r_ptr;
    w_idx       = r_ptr;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_win_valid && req[w_idx]) begin
        w_win_valid = 1'b1;
        w_win       = w_idx;
      end
    end
  end

  byte_mux u_mux (
    .sel (r_addr),
    .d0  (r_mem0),
    .d1  (r_mem1),
    .d2  (r_mem2),
    .d3  (r_mem3),
    .y   (w_mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_gnt   <= 2'd0;
      r_we    <= 1'b0;
      r_addr  <= 2'd0;
      r_wdata <= 8'h00;
      r_ack   <= 4'b0000;
      r_rdata <= 8'h00;
      r_mem0  <= RESET_VAL;
      r_mem1  <= RESET_VAL;
      r_mem2  <= RESET_VAL;
      r_mem3  <= RESET_VAL;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_valid) begin
            r_gnt   <= w_win;
            r_we    <= we[w_win];
            r_addr  <= addr[{w_win, 1'b0} +: 2];
            r_wdata <= wdata[{w_win, 3'b000} +: 8];
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Only the latched copy is used, so the requester may change its inputs now.
          if (r_we) begin
            case (r_addr)
              2'd0: r_mem0 <= r_wdata;
              2'd1: r_mem1 <= r_wdata;
              2'd2: r_mem2 <= r_wdata;
              2'd3: r_mem3 <= r_wdata;
              default: r_mem0 <= r_wdata;
            endcase
            r_rdata <= r_wdata;
          end else begin
            r_rdata <= w_mux_y;
          end
          r_ack   <= 4'b0001 << r_gnt;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_ack   <= 4'b0000;
          r_ptr   <= r_gnt + 2'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack    = r_ack;
  assign rdata  = r_rdata;
  assign gnt_id = r_gnt;
  assign busy   = (r_state != S_IDLE);
  assign mem0   = r_mem0;
  assign mem1   = r_mem1;
  assign mem2   = r_mem2;
  assign mem3   = r_mem3;
endmodule

// File: tb/tb_byte_mem_arbiter.sv
// tb/tb_byte_mem_arbiter.sv - scoreboard bench for byte_mem_arbiter
// Expected transactions are queued when a request is driven and popped at each ack.

module tb_byte_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  ack;
  logic [7:0]  rdata;
  logic [1:0]  gnt_id;
  logic        busy;
  logic [7:0]  mem0, mem1, mem2, mem3;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] m [4];
  int         n_chk = 0;
  int         n_fail = 0;
  int         n;
  logic       ok;

  byte_mem_arbiter #(.RESET_VAL(8'h00)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .ack    (ack),
    .rdata  (rdata),
    .gnt_id (gnt_id),
    .busy   (busy),
    .mem0   (mem0),
    .mem1   (mem1),
    .mem2   (mem2),
    .mem3   (mem3)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic w, input logic [1:0] a, input logic [7:0] d);
    req[i]         = 1'b1;
    we[i]          = w;
    addr[2*i +: 2] = a;
    wdata[8*i +: 8] = d;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic w, input logic [1:0] a, input logic [7:0] d);
    exp_t x;
    x.id   = id;
    x.data = w ? d : m[a];
    if (w) m[a] = d;
    exp_q.push_back(x);
  endtask

  task automatic wait_ack(input int limit, output int cnt, output logic seen);
    cnt  = 0;
    seen = 1'b0;
    while (cnt < limit && !seen) begin
      @(negedge clk);
      cnt++;
      if (ack !== 4'b0000) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req   = 4'($urandom);
    we    = 4'($urandom);
    addr  = 8'($urandom);
    wdata = $urandom;
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    repeat (3) @(negedge clk);
    n_chk++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    n_chk++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_chk++; if (gnt_id !== 2'd0) begin n_fail++; $display("FAIL reset_gnt: got %0d expected 0", gnt_id); end
    n_chk++; if ({mem3, mem2, mem1, mem0} !== 32'h0) begin
      n_fail++; $display("FAIL reset_mem: got %h expected 00000000", {mem3, mem2, mem1, mem0});
    end
    @(posedge clk); #1;
    req   = 4'b0000;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0 at cycle %0d", busy, c); end
    end
  endtask

  task automatic test_write_read;
    @(posedge clk); #1;
    set_req(2, 1'b1, 2'd3, 8'hA5);
    push_exp(2'd2, 1'b1, 2'd3, 8'hA5);
    wait_ack(10, n, ok);
    n_chk++; if (!ok || n != 3) begin n_fail++; $display("FAIL wr_latency: got seen=%b after %0d cycles expected 3", ok, n); end
    e = exp_q.pop_front();
    n_chk++; if (ack !== (4'b0001 << e.id)) begin n_fail++; $display("FAIL wr_ack: got %b expected %b", ack, 4'b0001 << e.id); end
    n_chk++; if (rdata !== e.data) begin n_fail++; $display("FAIL wr_rdata: got %h expected %h", rdata, e.data); end
    n_chk++; if (mem3 !== 8'hA5) begin n_fail++; $display("FAIL wr_mem3: got %h expected a5", mem3); end
    @(posedge clk); #1;
    we[2] = 1'b0;
    push_exp(2'd2, 1'b0, 2'd3, 8'h00);
    wait_ack(10, n, ok);
    n_chk++; if (!ok || n != 3) begin n_fail++; $display("FAIL rd_latency: got seen=%b after %0d cycles expected 3", ok, n); end
    e = exp_q.pop_front();
    n_chk++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL rd_ack: got %b expected 0100", ack); end
    n_chk++; if (rdata !== e.data) begin n_fail++; $display("FAIL rd_rdata: got %h expected %h", rdata, e.data); end
    @(posedge clk); #1;
    req[2] = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    // Preload through requester 3 so the pointer ends at 0.
    for (int a = 0; a < 4; a++) begin
      @(posedge clk); #1;
      set_req(3, 1'b1, 2'(a), vals[a]);
      push_exp(2'd3, 1'b1, 2'(a), vals[a]);
      wait_ack(10, n, ok);
      e = exp_q.pop_front();
      n_chk++; if (!ok || ack !== 4'b1000 || rdata !== e.data) begin
        n_fail++; $display("FAIL preload_%0d: got ack=%b rdata=%h expected ack=1000 rdata=%h", a, ack, rdata, e.data);
      end
      @(posedge clk); #1;
      req[3] = 1'b0;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 2'(i), 8'h00);
    for (int k = 0; k < 5; k++) push_exp(2'(k % 4), 1'b0, 2'(k % 4), 8'h00);
    for (int k = 0; k < 5; k++) begin
      wait_ack(12, n, ok);
      e = exp_q.pop_front();
      n_chk++; if (!ok || n != 3) begin n_fail++; $display("FAIL rr_spacing_%0d: got seen=%b after %0d cycles expected 3", k, ok, n); end
      n_chk++; if (ack !== (4'b0001 << e.id) || gnt_id !== e.id) begin
        n_fail++; $display("FAIL rr_order_%0d: got ack=%b gnt=%0d expected ack=%b gnt=%0d", k, ack, gnt_id, 4'b0001 << e.id, e.id);
      end
      n_chk++; if (rdata !== e.data) begin n_fail++; $display("FAIL rr_rdata_%0d: got %h expected %h", k, rdata, e.data); end
    end
    @(posedge clk); #1;
    req = 4'b0000;
  endtask

  task automatic test_pointer_wrap;
    @(posedge clk); #1;
    set_req(3, 1'b0, 2'd0, 8'h00);
    push_exp(2'd3, 1'b0, 2'd0, 8'h00);
    wait_ack(10, n, ok);
    e = exp_q.pop_front();
    n_chk++; if (!ok || gnt_id !== 2'd3 || rdata !== e.data) begin
      n_fail++; $display("FAIL wrap_pre: got gnt=%0d rdata=%h expected gnt=3 rdata=%h", gnt_id, rdata, e.data);
    end
    @(posedge clk); #1;
    req[3] = 1'b0;
    @(posedge clk); #1;
    set_req(0, 1'b0, 2'd1, 8'h00);
    set_req(3, 1'b0, 2'd2, 8'h00);
    push_exp(2'd0, 1'b0, 2'd1, 8'h00);
    push_exp(2'd3, 1'b0, 2'd2, 8'h00);
    wait_ack(10, n, ok);
    e = exp_q.pop_front();
    n_chk++; if (!ok || ack !== 4'b0001 || gnt_id !== e.id || rdata !== e.data) begin
      n_fail++; $display("FAIL wrap_first: got ack=%b gnt=%0d rdata=%h expected ack=0001 gnt=0 rdata=%h", ack, gnt_id, rdata, e.data);
    end
    @(posedge clk); #1;
    req[0] = 1'b0;
    wait_ack(10, n, ok);
    e = exp_q.pop_front();
    n_chk++; if (!ok || n != 3 || ack !== 4'b1000 || gnt_id !== e.id || rdata !== e.data) begin
      n_fail++; $display("FAIL wrap_second: got ack=%b gnt=%0d rdata=%h after %0d expected ack=1000 gnt=3 rdata=%h after 3", ack, gnt_id, rdata, n, e.data);
    end
    @(posedge clk); #1;
    req = 4'b0000;
  endtask

  task automatic test_input_isolation;
    @(posedge clk); #1;
    set_req(1, 1'b1, 2'd2, 8'h5A);
    push_exp(2'd1, 1'b1, 2'd2, 8'h5A);
    @(posedge clk); #1;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL iso_busy: got %b expected 1", busy); end
    wdata[15:8] = 8'hFF;
    wait_ack(10, n, ok);
    e = exp_q.pop_front();
    n_chk++; if (!ok || ack !== 4'b0010 || rdata !== e.data) begin
      n_fail++; $display("FAIL iso_rdata: got ack=%b rdata=%h expected ack=0010 rdata=%h", ack, rdata, e.data);
    end
    n_chk++; if (mem2 !== 8'h5A) begin n_fail++; $display("FAIL iso_mem2: got %h expected 5a", mem2); end
    @(posedge clk); #1;
    req = 4'b0000;
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    set_req(0, 1'b1, 2'd1, 8'h77);
    @(posedge clk); #1;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre: got %b expected 1", busy); end
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    #1;
    n_chk++; if (ack !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0 || rdata !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset_state: got ack=%b busy=%b gnt=%0d rdata=%h expected 0000 0 0 00", ack, busy, gnt_id, rdata);
    end
    @(posedge clk); #1;
    n_chk++; if (mem1 !== 8'h00) begin n_fail++; $display("FAIL mid_mem1: got %h expected 00", mem1); end
    req   = 4'b0000;
    rst_n = 1'b1;
    wait_ack(5, n, ok);
    n_chk++; if (ok || mem1 !== 8'h00) begin n_fail++; $display("FAIL mid_no_ack: got ack_seen=%b mem1=%h expected 0 00", ok, mem1); end
    // With ptr back at 0, requester 1 outranks requester 3.
    @(posedge clk); #1;
    set_req(1, 1'b0, 2'd1, 8'h00);
    set_req(3, 1'b0, 2'd0, 8'h00);
    push_exp(2'd1, 1'b0, 2'd1, 8'h00);
    wait_ack(10, n, ok);
    e = exp_q.pop_front();
    n_chk++; if (!ok || ack !== 4'b0010 || gnt_id !== e.id || rdata !== e.data) begin
      n_fail++; $display("FAIL mid_ptr: got ack=%b gnt=%0d rdata=%h expected ack=0010 gnt=1 rdata=%h", ack, gnt_id, rdata, e.data);
    end
    @(posedge clk); #1;
    req = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    we    = 4'b0000;
    addr  = 8'h00;
    wdata = 32'h0;
    test_reset;
    test_write_read;
    test_round_robin;
    test_pointer_wrap;
    test_input_isolation;
    test_reset_mid;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
